// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard unit
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// rtl/hazard_ctrl_fwd_sel.sv - E-stage operand forwarding select for one source register
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] Rs,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output fwd_sel_t   Sel
);

  // Youngest producer (M) wins over W; x0 is hardwired zero and never forwarded
  always_comb begin
    Sel = FWD_RF;
    if (RegWriteM && (RdM == Rs) && (Rs != REG_X0)) begin
      Sel = FWD_M;
    end else if (RegWriteW && (RdW == Rs) && (Rs != REG_X0)) begin
      Sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard unit: load-use stall, redirect flush, forwarding, memory-wait timeout (optional HAZARD_PERF_CNT_EN)
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       ResultSrcEb0,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       PCSrcE,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       StallW,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MemFault
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] LoadUseCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] MemWaitCnt
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT);

  mem_state_t    state, nextState;
  logic [CW-1:0] cnt, nextCnt;
  logic          setFault;
  logic          timeoutRel;
  logic          lwStall;
  logic          memStall;
  logic          redirect;
  fwd_sel_t      fwdA, fwdB;

  fwd_sel uFwdA (
    .Rs       (Rs1E),
    .RdM      (RdM),
    .RdW      (RdW),
    .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW),
    .Sel      (fwdA)
  );

  fwd_sel uFwdB (
    .Rs       (Rs2E),
    .RdM      (RdM),
    .RdW      (RdW),
    .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW),
    .Sel      (fwdB)
  );

  // All controls are gated by reset so the pipeline sees a quiet hazard unit while held
  always_comb begin
    timeoutRel = (state == WAIT) && (cnt == CNT_MAX);
    redirect   = PCSrcE && !reset;
    // A taken redirect kills the dependent D instruction, so no load-use stall is needed
    lwStall    = ResultSrcEb0 && (RdE != REG_X0) && ((RdE == Rs1D) || (RdE == Rs2D))
                 && !PCSrcE && !reset;
    memStall   = MemReqM && !MemReadyM && !timeoutRel && !reset;
    StallF     = lwStall || memStall;
    StallD     = lwStall || memStall;
    StallE     = memStall;
    StallM     = memStall;
    StallW     = memStall;
    // Redirects are held off while frozen; E keeps PCSrcE asserted until release
    FlushD     = redirect && !memStall;
    FlushE     = (lwStall || redirect) && !memStall;
    ForwardAE  = reset ? 2'b00 : fwdA;
    ForwardBE  = reset ? 2'b00 : fwdB;
  end

  // Memory-wait FSM: count stalled cycles and force release after MEM_TIMEOUT of them
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    setFault  = 1'b0;
    case (state)
      IDLE: begin
        if (MemReqM && !MemReadyM) begin
          nextState = WAIT;
          nextCnt   = CW'(1);
        end else begin
          nextCnt = '0;
        end
      end
      WAIT: begin
        if (MemReadyM || !MemReqM) begin
          nextState = IDLE;
          nextCnt   = '0;
        end else if (cnt == CNT_MAX) begin
          nextState = IDLE;
          nextCnt   = '0;
          setFault  = 1'b1;
        end else begin
          nextCnt = cnt + CW'(1);
        end
      end
      default: begin
        nextState = IDLE;
        nextCnt   = '0;
      end
    endcase
  end

  // State, wait counter and sticky fault flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      MemFault <= 1'b0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      if (setFault) begin
        MemFault <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Free-running wrap-around event counters for stall/flush profiling
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      LoadUseCnt <= '0;
      FlushCnt   <= '0;
      MemWaitCnt <= '0;
    end else begin
      if (lwStall) LoadUseCnt <= LoadUseCnt + CNT_W'(1);
      if (FlushE) FlushCnt <= FlushCnt + CNT_W'(1);
      if (memStall) MemWaitCnt <= MemWaitCnt + CNT_W'(1);
    end
  end
`else
  localparam int unusedCntW = CNT_W;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcEb0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemFault;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [7:0] LoadUseCnt, FlushCnt, MemWaitCnt;
`endif

  logic [11:0] obsVec;
  logic [11:0] expV;
  logic [11:0] expQ[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcEb0(ResultSrcEb0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemFault(MemFault)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .LoadUseCnt(LoadUseCnt), .FlushCnt(FlushCnt), .MemWaitCnt(MemWaitCnt)
`endif
  );

  assign obsVec = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
                   ForwardAE, ForwardBE, MemFault};

  function automatic logic [11:0] mk(input logic [4:0] st, input logic fd, input logic fe,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic mf);
    return {st, fd, fe, fa, fb, mf};
  endfunction

  task automatic quiet();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcEb0 = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    quiet();
    ResultSrcEb0 = 1; RdE = 5; Rs1D = 5; PCSrcE = 1; MemReqM = 1;
    RegWriteM = 1; RdM = 3; Rs1E = 3; RegWriteW = 1; RdW = 4; Rs2E = 4;
    expQ.push_back(mk(5'b00000, 0, 0, 2'b00, 2'b00, 0));
    @(negedge clk);
    expV = expQ.pop_front();
    total++;
    if (obsVec !== expV) begin
      bad++;
      $display("FAIL reset_held obs=%b exp=%b", obsVec, expV);
    end
    @(negedge clk);
    reset = 1'b0;
    quiet();
    expQ.push_back(mk(5'b00000, 0, 0, 2'b00, 2'b00, 0));
    #2;
    expV = expQ.pop_front();
    total++;
    if (obsVec !== expV) begin
      bad++;
      $display("FAIL reset_release obs=%b exp=%b", obsVec, expV);
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      quiet();
      ResultSrcEb0 = 1;
      case (i)
        0: begin RdE = 5; Rs1D = 5; expQ.push_back(mk(5'b11000, 0, 1, 2'b00, 2'b00, 0)); end
        1: begin RdE = 5; Rs1D = 1; Rs2D = 5; expQ.push_back(mk(5'b11000, 0, 1, 2'b00, 2'b00, 0)); end
        default: begin RdE = 0; Rs1D = 0; expQ.push_back(mk(5'b00000, 0, 0, 2'b00, 2'b00, 0)); end
      endcase
      @(negedge clk);
      expV = expQ.pop_front();
      total++;
      if (obsVec !== expV) begin
        bad++;
        $display("FAIL load_use_%0d obs=%b exp=%b", i, obsVec, expV);
      end
    end
  endtask

  task automatic test_forward();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      quiet();
      case (i)
        0: begin Rs1E = 7; RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1;
                 expQ.push_back(mk(5'b00000, 0, 0, 2'b10, 2'b00, 0)); end
        1: begin Rs1E = 7; RdM = 7; RdW = 7; RegWriteM = 0; RegWriteW = 1;
                 expQ.push_back(mk(5'b00000, 0, 0, 2'b01, 2'b00, 0)); end
        2: begin Rs2E = 0; RdM = 0; RdW = 0; RegWriteM = 1; RegWriteW = 1;
                 expQ.push_back(mk(5'b00000, 0, 0, 2'b00, 2'b00, 0)); end
        default: begin Rs1E = 7; Rs2E = 9; RdM = 7; RdW = 9; RegWriteM = 1; RegWriteW = 1;
                 expQ.push_back(mk(5'b00000, 0, 0, 2'b10, 2'b01, 0)); end
      endcase
      @(negedge clk);
      expV = expQ.pop_front();
      total++;
      if (obsVec !== expV) begin
        bad++;
        $display("FAIL forward_%0d obs=%b exp=%b", i, obsVec, expV);
      end
    end
  endtask

  task automatic test_branch_priority();
    next_cycle();
    quiet();
    ResultSrcEb0 = 1; RdE = 6; Rs2D = 6; PCSrcE = 1;
    expQ.push_back(mk(5'b00000, 1, 1, 2'b00, 2'b00, 0));
    @(negedge clk);
    expV = expQ.pop_front();
    total++;
    if (obsVec !== expV) begin
      bad++;
      $display("FAIL branch_priority obs=%b exp=%b", obsVec, expV);
    end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      quiet();
      PCSrcE = (i < 4);
      MemReqM = (i < 4);
      MemReadyM = (i == 3);
      if (i < 3) expQ.push_back(mk(5'b11111, 0, 0, 2'b00, 2'b00, 0));
      else if (i == 3) expQ.push_back(mk(5'b00000, 1, 1, 2'b00, 2'b00, 0));
      else expQ.push_back(mk(5'b00000, 0, 0, 2'b00, 2'b00, 0));
      @(negedge clk);
      expV = expQ.pop_front();
      total++;
      if (obsVec !== expV) begin
        bad++;
        $display("FAIL mem_wait_%0d obs=%b exp=%b", i, obsVec, expV);
      end
    end
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= TO + 3; i++) begin
      next_cycle();
      quiet();
      MemReqM = (i <= TO + 2);
      if (i <= TO) expQ.push_back(mk(5'b11111, 0, 0, 2'b00, 2'b00, 0));
      else if (i == TO + 1) expQ.push_back(mk(5'b00000, 0, 0, 2'b00, 2'b00, 0));
      else if (i == TO + 2) expQ.push_back(mk(5'b11111, 0, 0, 2'b00, 2'b00, 1));
      else expQ.push_back(mk(5'b00000, 0, 0, 2'b00, 2'b00, 1));
      @(negedge clk);
      expV = expQ.pop_front();
      total++;
      if (obsVec !== expV) begin
        bad++;
        $display("FAIL timeout_%0d obs=%b exp=%b", i, obsVec, expV);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      quiet();
      MemReqM = 1;
      expQ.push_back(mk(5'b11111, 0, 0, 2'b00, 2'b00, 1));
      @(negedge clk);
      expV = expQ.pop_front();
      total++;
      if (obsVec !== expV) begin
        bad++;
        $display("FAIL pre_reset_%0d obs=%b exp=%b", i, obsVec, expV);
      end
    end
    next_cycle();
    reset = 1'b1;
    expQ.push_back(mk(5'b00000, 0, 0, 2'b00, 2'b00, 0));
    #1;
    expV = expQ.pop_front();
    total++;
    if (obsVec !== expV) begin
      bad++;
      $display("FAIL reset_async obs=%b exp=%b", obsVec, expV);
    end
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if ({LoadUseCnt, FlushCnt, MemWaitCnt} !== 24'd0) begin
      bad++;
      $display("FAIL perf_reset obs=%h/%h/%h exp=0", LoadUseCnt, FlushCnt, MemWaitCnt);
    end
`endif
    MemReqM = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= TO + 2; i++) begin
      next_cycle();
      quiet();
      MemReqM = (i <= TO + 1);
      if (i <= TO) expQ.push_back(mk(5'b11111, 0, 0, 2'b00, 2'b00, 0));
      else if (i == TO + 1) expQ.push_back(mk(5'b00000, 0, 0, 2'b00, 2'b00, 0));
      else expQ.push_back(mk(5'b00000, 0, 0, 2'b00, 2'b00, 1));
      @(negedge clk);
      expV = expQ.pop_front();
      total++;
      if (obsVec !== expV) begin
        bad++;
        $display("FAIL post_reset_%0d obs=%b exp=%b", i, obsVec, expV);
      end
    end
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if (MemWaitCnt !== 8'(TO) || LoadUseCnt !== 8'd0 || FlushCnt !== 8'd0) begin
      bad++;
      $display("FAIL perf_count obs=%0d/%0d/%0d exp=0/0/%0d", LoadUseCnt, FlushCnt, MemWaitCnt, TO);
    end
`endif
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      quiet();
      Rs1E = 3; RdW = 3; RegWriteW = 1;
      MemReqM = (i < 5);
      MemReadyM = (i == 1) || (i == 3);
      if (i == 0 || i == 2 || i == 4) expQ.push_back(mk(5'b11111, 0, 0, 2'b01, 2'b00, 1));
      else expQ.push_back(mk(5'b00000, 0, 0, 2'b01, 2'b00, 1));
      @(negedge clk);
      expV = expQ.pop_front();
      total++;
      if (obsVec !== expV) begin
        bad++;
        $display("FAIL back_to_back_%0d obs=%b exp=%b", i, obsVec, expV);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
